// File: rtl/button_event.sv
// rtl/button_event.sv - debounced level to press/release/long_press/repeat events
// Auto-repeat is compiled in only when BUTTON_EVENT_REPEAT_EN is defined.
module button_event #(
  parameter int TICK_MAX  = 100_000,
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200
) (
  input  logic ck,
  input  logic rst,
  input  logic button_deb,
  output logic press,
  output logic release_evt,
  output logic long_press,
  output logic repeat_evt,
  output logic held,
  output logic was_long
);

  localparam int MS_MAX = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
  localparam int MW     = $clog2(MS_MAX + 1);
  localparam int PW     = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_MAX - 1);
  localparam logic [MW-1:0] LONG_LAST  = MW'(LONG_MS - 1);
`ifdef BUTTON_EVENT_REPEAT_EN
  localparam logic [MW-1:0] REP_LAST   = MW'(REPEAT_MS - 1);
`endif

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PRESSED = 2'd1;
  localparam logic [1:0] S_LONG    = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [MW-1:0] ms_q, ms_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;
  logic          repeat_q, repeat_d;
  logic          held_q, held_d;
  logic          was_long_q, was_long_d;
  logic          ms_tick;

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    ms_d       = ms_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    repeat_d   = 1'b0;
    was_long_d = was_long_q;
    ms_tick    = (presc_q == PRESC_LAST);

    if (state_q != S_IDLE) begin
      presc_d = ms_tick ? '0 : presc_q + 1'b1;
    end

    // Release is tested first so it wins over a coincident long/repeat threshold.
    case (state_q)
      S_IDLE: begin
        if (button_deb) begin
          state_d = S_PRESSED;
          press_d = 1'b1;
        end
      end
      S_PRESSED: begin
        if (!button_deb) begin
          state_d    = S_IDLE;
          release_d  = 1'b1;
          was_long_d = 1'b0;
        end else if (ms_tick) begin
          if (ms_q == LONG_LAST) begin
            state_d = S_LONG;
            long_d  = 1'b1;
          end else begin
            ms_d = ms_q + 1'b1;
          end
        end
      end
      S_LONG: begin
        if (!button_deb) begin
          state_d    = S_IDLE;
          release_d  = 1'b1;
          was_long_d = 1'b1;
        end
`ifdef BUTTON_EVENT_REPEAT_EN
        else if (ms_tick) begin
          if (ms_q == REP_LAST) begin
            repeat_d = 1'b1;
            ms_d     = '0;
          end else begin
            ms_d = ms_q + 1'b1;
          end
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // Each state measures its hold time from its own entry.
    if (state_d != state_q) begin
      presc_d = '0;
      ms_d    = '0;
    end

    held_d = (state_d != S_IDLE);
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      ms_q       <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
      held_q     <= 1'b0;
      was_long_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      ms_q       <= ms_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
      held_q     <= held_d;
      was_long_q <= was_long_d;
    end
  end

  assign press       = press_q;
  assign release_evt = release_q;
  assign long_press  = long_q;
  assign repeat_evt  = repeat_q;
  assign held        = held_q;
  assign was_long    = was_long_q;

endmodule

// File: tb/tb_button_event.sv
// tb/tb_button_event.sv - scoreboard bench for button_event (TICK_MAX=4, LONG_MS=5, REPEAT_MS=2)
// Repeat expectations follow BUTTON_EVENT_REPEAT_EN.
module tb_button_event;

  localparam int TICK_MAX  = 4;
  localparam int LONG_MS   = 5;
  localparam int REPEAT_MS = 2;
  localparam int LONG_CYC  = LONG_MS * TICK_MAX;
  localparam int REP_CYC   = REPEAT_MS * TICK_MAX;

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_LONG    = 2;
  localparam int K_REPEAT  = 3;

  typedef struct {
    int kind;
    int cyc;
    bit wl;
  } ev_t;

  logic ck = 1'b0;
  logic rst = 1'b1;
  logic button_deb = 1'b1;
  logic press, release_evt, long_press, repeat_evt, held, was_long;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  ev_t  sb[$];

  button_event #(
    .TICK_MAX(TICK_MAX),
    .LONG_MS(LONG_MS),
    .REPEAT_MS(REPEAT_MS)
  ) dut (
    .ck(ck),
    .rst(rst),
    .button_deb(button_deb),
    .press(press),
    .release_evt(release_evt),
    .long_press(long_press),
    .repeat_evt(repeat_evt),
    .held(held),
    .was_long(was_long)
  );

  always #5 ck = ~ck;
  always @(posedge ck) cyc <= cyc + 1;

  // Pops one expected event per observed pulse and checks kind, cycle and was_long.
  always @(negedge ck) begin
    if (mon_en) begin
      logic [3:0] fired;
      fired = {repeat_evt, long_press, release_evt, press};
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_event kind=%0d expected_cycle=%0d now=%0d", sb[0].kind, sb[0].cyc, cyc);
        void'(sb.pop_front());
      end
      if (press && release_evt) begin
        checks++;
        failures++;
        $display("FAIL press_release_overlap cycle=%0d", cyc);
      end
      for (int k = 0; k < 4; k++) begin
        if (fired[k]) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event kind=%0d cycle=%0d (scoreboard empty)", k, cyc);
          end else begin
            ev_t e;
            e = sb.pop_front();
            if (e.kind !== k || e.cyc !== cyc) begin
              failures++;
              $display("FAIL event_order got kind=%0d cycle=%0d expected kind=%0d cycle=%0d", k, cyc, e.kind, e.cyc);
            end else if (k == K_RELEASE && was_long !== e.wl) begin
              failures++;
              $display("FAIL was_long got=%0b expected=%0b cycle=%0d", was_long, e.wl, cyc);
            end
          end
        end
      end
    end
  end

  function automatic void push_ev(input int kind, input int at, input bit wl);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    e.wl   = wl;
    sb.push_back(e);
  endfunction

  // Caller is at a negedge; button is sampled high on n edges then low.
  task automatic press_hold(input int n, input int gap);
    int e0;
    e0 = cyc + 1;
    push_ev(K_PRESS, e0, 1'b0);
    if (n > LONG_CYC) begin
      push_ev(K_LONG, e0 + LONG_CYC, 1'b0);
`ifdef BUTTON_EVENT_REPEAT_EN
      for (int t = e0 + LONG_CYC + REP_CYC; t < e0 + n; t += REP_CYC) push_ev(K_REPEAT, t, 1'b0);
`endif
    end
    push_ev(K_RELEASE, e0 + n, n > LONG_CYC);
    button_deb = 1'b1;
    @(negedge ck);
    checks++;
    if (held !== 1'b1) begin
      failures++;
      $display("FAIL held_after_press got=%0b expected=1", held);
    end
    repeat (n - 1) @(negedge ck);
    button_deb = 1'b0;
    repeat (gap) @(negedge ck);
    if (gap > 0) begin
      checks++;
      if (held !== 1'b0) begin
        failures++;
        $display("FAIL held_after_release got=%0b expected=0", held);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({press, release_evt, long_press, repeat_evt, held, was_long} !== 6'b0) begin
      failures++;
      $display("FAIL %s outputs got=%b expected=000000", tag, {press, release_evt, long_press, repeat_evt, held, was_long});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    button_deb = 1'b1;
    repeat (3) @(negedge ck);
    check_all_zero("reset");
    push_ev(K_PRESS, cyc + 1, 1'b0);
    mon_en = 1'b1;
    rst = 1'b0;
    @(negedge ck);
    checks++;
    if (held !== 1'b1) begin
      failures++;
      $display("FAIL reset_held got=%0b expected=1", held);
    end
    push_ev(K_RELEASE, cyc + 1, 1'b0);
    button_deb = 1'b0;
    repeat (3) @(negedge ck);
  endtask

  task automatic test_short();
    press_hold(10, 3);
  endtask

  task automatic test_long();
    press_hold(50, 3);
    checks++;
    if (was_long !== 1'b1) begin
      failures++;
      $display("FAIL was_long_hold got=%0b expected=1", was_long);
    end
  endtask

  task automatic test_tie();
    press_hold(LONG_CYC, 3);
  endtask

  task automatic test_back_to_back();
    press_hold(6, 1);
    press_hold(6, 3);
  endtask

  task automatic test_reset_mid_long();
    int e0;
    e0 = cyc + 1;
    push_ev(K_PRESS, e0, 1'b0);
    push_ev(K_LONG, e0 + LONG_CYC, 1'b0);
    button_deb = 1'b1;
    repeat (25) @(negedge ck);
    rst = 1'b1;
    @(negedge ck);
    check_all_zero("reset_mid_long");
    push_ev(K_PRESS, cyc + 1, 1'b0);
    rst = 1'b0;
    repeat (4) @(negedge ck);
    push_ev(K_RELEASE, cyc + 1, 1'b0);
    button_deb = 1'b0;
    repeat (3) @(negedge ck);
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_tie();
    test_back_to_back();
    test_reset_mid_long();
    repeat (5) @(negedge ck);
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_drain remaining=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
